// File: rtl/tpm_exec_pkg.sv
// Shared definitions for the TPM execution engine: management op states,
// TPM2_Startup types, startup sequencer state encoding and failure codes.
package tpm_exec_pkg;

  // Management module operational states
  localparam logic [2:0] OP_POWER_OFF   = 3'd0;
  localparam logic [2:0] OP_INIT        = 3'd1;
  localparam logic [2:0] OP_STARTUP     = 3'd2;
  localparam logic [2:0] OP_OPERATIONAL = 3'd3;
  localparam logic [2:0] OP_SHUTDOWN    = 3'd4;

  // TPM2_Startup types
  localparam logic [2:0] TPM_RESET   = 3'd1;
  localparam logic [2:0] TPM_RESTART = 3'd2;
  localparam logic [2:0] TPM_RESUME  = 3'd3;

  // Failure code reported when the requested startup type is not recognised
  localparam logic [3:0] FAIL_INVALID_TYPE = 4'hF;

  // Startup sequencer states
  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LAUNCH = 3'd1,
    SEQ_WAIT   = 3'd2,
    SEQ_DONE   = 3'd3,
    SEQ_FAIL   = 3'd4
  } seq_state_e;

  // True for the three startup types the engine knows how to run
  function automatic logic startup_type_valid(input logic [2:0] startup_type);
    return (startup_type == TPM_RESET) ||
           (startup_type == TPM_RESTART) ||
           (startup_type == TPM_RESUME);
  endfunction

endpackage

// File: rtl/startup_stage_timer.sv
// Per-stage watchdog for the startup sequencer. Counts enabled cycles from a
// clear and flags expiry once the count reaches TIMEOUT_CYCLES-1; the count
// then holds until the next clear.
module startup_stage_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 10
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count;

  // Expiry is a pure decode of the count so the sequencer sees it in the
  // same cycle the limit is reached.
  assign expired = (count == LAST_COUNT);

  // Cycle counter: restart on clear, advance while enabled, saturate at the limit
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/startup_sequencer.sv
// TPM2_Startup sequencer. Walks the startup-capable submodules (NV index,
// clock, PCR, ACT, memory) one at a time: a one-cycle start pulse plus the
// latched startup type, then a wait for that submodule's done level.
// Overall done/fail is held until the management op state leaves STARTUP.
// Build option: define STARTUP_TIMEOUT_EN to add a per-stage watchdog that
// fails the sequence with {1'b1, stage} when a submodule never finishes.
module startup_sequencer
  import tpm_exec_pkg::*;
#(
  parameter int NUM_SUBS       = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 10
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic [2:0]          op_state_i,
  input  logic [2:0]          startup_type_i,
  input  logic                start_i,
  input  logic [NUM_SUBS-1:0] sub_done_i,
  output logic [NUM_SUBS-1:0] sub_start_o,
  output logic [2:0]          sub_type_o,
  output logic                seq_busy_o,
  output logic                seq_done_o,
  output logic                seq_fail_o,
  output logic [3:0]          fail_code_o,
  output logic [2:0]          stage_o
);

  // Stage index is a 3-bit field (also embedded in fail_code), and the
  // watchdog counter must be able to reach its limit.
  if (NUM_SUBS < 1 || NUM_SUBS > 8 || TIMEOUT_CYCLES < 2 ||
      (2 ** TIMEOUT_W) < TIMEOUT_CYCLES) begin : g_param_check
    $error("startup_sequencer: unsupported NUM_SUBS/TIMEOUT_CYCLES/TIMEOUT_W");
  end

  localparam logic [2:0] LAST_STAGE = 3'(NUM_SUBS - 1);

  seq_state_e state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic [2:0] type_q, type_d;
  logic [3:0] fail_code_q, fail_code_d;

  logic [NUM_SUBS-1:0] sub_start_q, sub_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;

  logic in_startup;
  logic stage_done;
  logic timer_expired;

  assign in_startup = (op_state_i == OP_STARTUP);
  // Only the current stage's done level matters; the others are ignored.
  assign stage_done = sub_done_i[stage_q];

`ifdef STARTUP_TIMEOUT_EN
  // Watchdog runs only while waiting; LAUNCH (and every other state) clears it.
  startup_stage_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_stage_timer (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .clear     (state_q != SEQ_WAIT),
    .enable    (state_q == SEQ_WAIT),
    .expired   (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  // State register together with the registered copies of every output
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= SEQ_IDLE;
      stage_q     <= '0;
      type_q      <= '0;
      fail_code_q <= '0;
      sub_start_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values computed by the combinational blocks.
      state_q     <= state_d;
      stage_q     <= stage_d;
      type_q      <= type_d;
      fail_code_q <= fail_code_d;
      sub_start_q <= sub_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state logic: stage progression, abort, watchdog and status capture
  always_comb begin
    // NOTE: hold-by-default assignments first so no path leaves a variable
    // unassigned, which would infer a latch.
    state_d     = state_q;
    stage_d     = stage_q;
    type_d      = type_q;
    fail_code_d = fail_code_q;

    unique case (state_q)
      SEQ_IDLE: begin
        if (in_startup && start_i) begin
          if (startup_type_valid(startup_type_i)) begin
            type_d  = startup_type_i;
            stage_d = '0;
            state_d = SEQ_LAUNCH;
          end else begin
            fail_code_d = FAIL_INVALID_TYPE;
            state_d     = SEQ_FAIL;
          end
        end
      end

      // Single pulse cycle; the previous done level may still be stale here.
      SEQ_LAUNCH: begin
        state_d = in_startup ? SEQ_WAIT : SEQ_IDLE;
      end

      // A done in the expiry cycle still counts as success.
      SEQ_WAIT: begin
        if (!in_startup) begin
          state_d = SEQ_IDLE;
        end else if (stage_done) begin
          if (stage_q == LAST_STAGE) begin
            state_d = SEQ_DONE;
          end else begin
            stage_d = stage_q + 3'd1;
            state_d = SEQ_LAUNCH;
          end
        end else if (timer_expired) begin
          fail_code_d = {1'b1, stage_q};
          state_d     = SEQ_FAIL;
        end
      end

      SEQ_DONE, SEQ_FAIL: begin
        if (!in_startup) begin
          state_d = SEQ_IDLE;
        end
      end

      default: state_d = SEQ_IDLE;
    endcase

    // Whatever the route back to IDLE, the reported context is wiped.
    if (state_d == SEQ_IDLE) begin
      stage_d     = '0;
      type_d      = '0;
      fail_code_d = '0;
    end
  end

  // Output decode from the next state so the registered outputs line up with it
  always_comb begin
    sub_start_d = '0;
    if (state_d == SEQ_LAUNCH) begin
      sub_start_d = NUM_SUBS'(1) << stage_d;
    end
    busy_d = (state_d == SEQ_LAUNCH) || (state_d == SEQ_WAIT);
    done_d = (state_d == SEQ_DONE);
    fail_d = (state_d == SEQ_FAIL);
  end

  assign sub_start_o = sub_start_q;
  assign sub_type_o  = type_q;
  assign seq_busy_o  = busy_q;
  assign seq_done_o  = done_q;
  assign seq_fail_o  = fail_q;
  assign fail_code_o = fail_code_q;
  assign stage_o     = stage_q;

endmodule

// File: tb/tb_startup_sequencer.sv
// Self-checking bench for startup_sequencer. A cycle-level reference model of
// the startup rules runs beside the DUT and every output is compared each
// cycle; directed scenarios add hand-computed literal expectations.
// Watchdog scenarios are exercised when STARTUP_TIMEOUT_EN is defined.
module tb_startup_sequencer;

  localparam int NUM_SUBS = 5;
`ifdef STARTUP_TIMEOUT_EN
  localparam int TMO   = 16;
  localparam int TW    = 4;
  localparam bit WD_ON = 1'b1;
`else
  localparam int TMO   = 1024;
  localparam int TW    = 10;
  localparam bit WD_ON = 1'b0;
`endif

  localparam logic [2:0] ST_STARTUP = 3'b010;
  localparam logic [2:0] ST_OPER    = 3'b011;

  logic                clk;
  logic                rst_n;
  logic [2:0]          op_state;
  logic [2:0]          startup_type;
  logic                start;
  logic [NUM_SUBS-1:0] sub_done;
  logic [NUM_SUBS-1:0] sub_start;
  logic [2:0]          sub_type;
  logic                seq_busy;
  logic                seq_done;
  logic                seq_fail;
  logic [3:0]          fail_code;
  logic [2:0]          stage;

  startup_sequencer #(
    .NUM_SUBS       (NUM_SUBS),
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_W      (TW)
  ) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .op_state_i     (op_state),
    .startup_type_i (startup_type),
    .start_i        (start),
    .sub_done_i     (sub_done),
    .sub_start_o    (sub_start),
    .sub_type_o     (sub_type),
    .seq_busy_o     (seq_busy),
    .seq_done_o     (seq_done),
    .seq_fail_o     (seq_fail),
    .fail_code_o    (fail_code),
    .stage_o        (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit         m_busy, m_launch, m_done, m_fail;
  int         m_stage, m_wait;
  logic [2:0] m_type;
  logic [3:0] m_code;

  task automatic model_clear();
    m_busy = 0; m_launch = 0; m_done = 0; m_fail = 0;
    m_stage = 0; m_wait = 0; m_type = '0; m_code = '0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [2:0] ty,
                            input logic st, input logic [NUM_SUBS-1:0] dn);
    bit in_su;
    in_su = (op == ST_STARTUP);
    if (m_busy) begin
      if (!in_su) model_clear();
      else if (m_launch) begin
        m_launch = 0;
        m_wait   = 0;
      end else if (dn[m_stage]) begin
        if (m_stage == NUM_SUBS - 1) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_stage++; m_launch = 1;
        end
      end else if (WD_ON && m_wait == TMO - 1) begin
        m_busy = 0; m_fail = 1; m_code = {1'b1, 3'(m_stage)};
      end else m_wait++;
    end else if (m_done || m_fail) begin
      if (!in_su) model_clear();
    end else if (in_su && st) begin
      if (ty >= 3'd1 && ty <= 3'd3) begin
        m_type = ty; m_stage = 0; m_busy = 1; m_launch = 1;
      end else begin
        m_fail = 1; m_code = 4'hF;
      end
    end
  endtask

  // Start pulses seen, in order, for literal sequence checks
  logic [NUM_SUBS-1:0] pulses[$];

  // Model update on each edge, then compare once the DUT has settled
  always @(posedge clk) begin
    if (!rst_n) model_clear();
    else model_step(op_state, startup_type, start, sub_done);
    #2;
    if (sub_start != '0) pulses.push_back(sub_start);
    check("sub_start", 32'(sub_start), m_launch ? (32'd1 << m_stage) : 32'd0);
    check("sub_type",  32'(sub_type),  32'(m_type));
    check("seq_busy",  32'(seq_busy),  32'(m_busy));
    check("seq_done",  32'(seq_done),  32'(m_done));
    check("seq_fail",  32'(seq_fail),  32'(m_fail));
    check("fail_code", 32'(fail_code), 32'(m_code));
    check("stage",     32'(stage),     32'(m_stage));
  end

  // ---------------- submodule responders ----------------
  // Each submodule drops done on its start pulse and raises it delay[i]
  // negedges later; delay 0 means it never finishes.
  int                  delay[NUM_SUBS];
  int                  cnt[NUM_SUBS];
  logic [NUM_SUBS-1:0] preset_mask;
  int                  preset_gen;
  int                  seen_gen;

  initial begin
    sub_done = '0;
    seen_gen = 0;
    for (int i = 0; i < NUM_SUBS; i++) cnt[i] = 0;
  end

  always @(negedge clk) begin
    if (preset_gen != seen_gen) begin
      seen_gen = preset_gen;
      sub_done = sub_done | preset_mask;
    end
    for (int i = 0; i < NUM_SUBS; i++) begin
      if (sub_start[i]) begin
        sub_done[i] = 1'b0;
        cnt[i]      = delay[i];
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) sub_done[i] = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3, input int d4);
    delay[0] = d0; delay[1] = d1; delay[2] = d2; delay[3] = d3; delay[4] = d4;
  endtask

  // Returns on the negedge after the sampling edge (first cycle of the response)
  task automatic pulse_start(input logic [2:0] ty);
    @(negedge clk);
    startup_type = ty;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    int i;
    i = 0;
    while (!(seq_done || seq_fail) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(seq_done | seq_fail), 32'd1);
  endtask

  task automatic leave_startup();
    @(negedge clk);
    op_state = ST_OPER;
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n        = 1'b0;
    op_state     = 3'd0;
    startup_type = 3'd0;
    start        = 1'b0;
    preset_mask  = '0;
    preset_gen   = 0;
    set_delays(3, 3, 3, 3, 3);
    tick(3);
    check("rst_busy", 32'(seq_busy), 32'd0);
    check("rst_start", 32'(sub_start), 32'd0);
    check("rst_code", 32'(fail_code), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Full TPM_RESET sequence; stage 4 done pre-asserted (ignored until its
    // turn) and a stray start mid-sequence (ignored).
    preset_mask = 5'b10000;
    preset_gen++;
    tick(1);
    op_state = ST_STARTUP;
    pulses.delete();
    pulse_start(3'd1);
    check("t1_first_pulse", 32'(sub_start), 32'h01);
    tick(5);
    pulse_start(3'd1);
    wait_end(200, "t1_finish");
    check("t1_done", 32'(seq_done), 32'd1);
    check("t1_fail", 32'(seq_fail), 32'd0);
    check("t1_type", 32'(sub_type), 32'd1);
    check("t1_npulses", 32'(pulses.size()), 32'd5);
    for (int i = 0; i < 5 && i < pulses.size(); i++)
      check($sformatf("t1_pulse%0d", i), 32'(pulses[i]), 32'd1 << i);
    leave_startup();
    check("t1_cleared", 32'(seq_done), 32'd0);

    // start_i outside STARTUP is ignored
    pulses.delete();
    pulse_start(3'd1);
    tick(3);
    check("offstate_busy", 32'(seq_busy), 32'd0);
    check("offstate_pulses", 32'(pulses.size()), 32'd0);

    // Invalid startup type
    op_state = ST_STARTUP;
    pulses.delete();
    pulse_start(3'd5);
    check("t2_fail", 32'(seq_fail), 32'd1);
    check("t2_code", 32'(fail_code), 32'hF);
    tick(2);
    check("t2_npulses", 32'(pulses.size()), 32'd0);
    check("t2_type", 32'(sub_type), 32'd0);
    leave_startup();
    check("t2_cleared", 32'(fail_code), 32'd0);

    // Abort while waiting on stage 1
    set_delays(3, 50, 3, 3, 3);
    op_state = ST_STARTUP;
    pulse_start(3'd2);
    for (int i = 0; i < 40 && !(stage == 3'd1 && seq_busy && sub_start == '0); i++) tick(1);
    tick(2);
    check("t4_in_wait1", 32'(stage), 32'd1);
    leave_startup();
    check("t4_busy", 32'(seq_busy), 32'd0);
    check("t4_done", 32'(seq_done), 32'd0);
    check("t4_fail", 32'(seq_fail), 32'd0);
    check("t4_stage", 32'(stage), 32'd0);
    tick(60);

    // PCR stage slow or absent
    op_state = ST_STARTUP;
`ifdef STARTUP_TIMEOUT_EN
    set_delays(3, 3, 0, 3, 3);
    pulse_start(3'd1);
    wait_end(200, "t3_finish");
    check("t3_fail", 32'(seq_fail), 32'd1);
    check("t3_code", 32'(fail_code), 32'hA);
    check("t3_done", 32'(seq_done), 32'd0);
`else
    set_delays(3, 3, 40, 3, 3);
    pulse_start(3'd1);
    wait_end(300, "t3_finish");
    check("t3_done", 32'(seq_done), 32'd1);
    check("t3_code", 32'(fail_code), 32'd0);
`endif
    leave_startup();

    // Last-stage done lands on the watchdog expiry cycle (when enabled)
    set_delays(3, 3, 3, 3, TMO);
    op_state = ST_STARTUP;
    pulse_start(3'd1);
    wait_end(2000, "t5_finish");
    check("t5_done", 32'(seq_done), 32'd1);
    check("t5_fail", 32'(seq_fail), 32'd0);
    leave_startup();

    // TPM_RESUME completes, status held, then cleared on leaving STARTUP
    set_delays(2, 2, 2, 2, 2);
    op_state = ST_STARTUP;
    pulse_start(3'd3);
    wait_end(200, "t6_finish");
    tick(5);
    check("t6_held", 32'(seq_done), 32'd1);
    check("t6_type", 32'(sub_type), 32'd3);
    check("t6_stage", 32'(stage), 32'd4);
    leave_startup();
    check("t6_done", 32'(seq_done), 32'd0);
    check("t6_type0", 32'(sub_type), 32'd0);
    check("t6_stage0", 32'(stage), 32'd0);
    check("t6_busy", 32'(seq_busy), 32'd0);
    check("t6_fail", 32'(seq_fail), 32'd0);
    check("t6_code", 32'(fail_code), 32'd0);
    check("t6_start", 32'(sub_start), 32'd0);

    // Asynchronous reset in the middle of a sequence
    set_delays(3, 3, 3, 3, 3);
    op_state = ST_STARTUP;
    pulse_start(3'd1);
    tick(6);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(seq_busy), 32'd0);
    check("arst_type", 32'(sub_type), 32'd0);
    check("arst_stage", 32'(stage), 32'd0);
    check("arst_start", 32'(sub_start), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("arst_norestart", 32'(seq_busy), 32'd0);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
